// File: rtl/otp_auth_pkg.sv
// -----------------------------------------------------------------------------
// otp_auth_pkg
// Shared definitions for the OTP authentication block:
//   state_e      - controller FSM state encoding
//   LFSR_SEED    - reset seed for the OTP generator LFSR (truncated/extended
//                  to the instantiated LFSR width)
//   hex_to_7seg  - hex digit to seven-segment pattern, bit order gfedcba,
//                  active-high segments
// -----------------------------------------------------------------------------
package otp_auth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [6:0] hex_to_7seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/otp_lfsr.sv
// -----------------------------------------------------------------------------
// otp_lfsr
// Free-running Fibonacci LFSR, stepped every clock. Shifts toward the MSB and
// inserts the XOR of the tap bits at bit 0. The MSB is always a tap, which
// makes the update invertible, so a non-zero state can never become zero; a
// zero next-state is still forced back to the seed as a guard.
//
// Parameters: W (width, 4..64), OUT_W (bits exported), SEED (reset value)
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-high; loads SEED
//   lfsr_low out  low OUT_W bits of the current state
// -----------------------------------------------------------------------------
module otp_lfsr
    import otp_auth_pkg::*;
#(
    parameter int             W     = 16,
    parameter int             OUT_W = 8,
    parameter logic [W-1:0]   SEED  = W'(LFSR_SEED)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [OUT_W-1:0] lfsr_low
);

    // Maximal-length tap sets for common widths; other widths fall back to
    // taps {W, W-1}, which keeps the no-zero property but not maximal length.
    function automatic logic [W-1:0] tap_mask(input int width);
        logic [63:0] m;
        case (width)
            4:       m = 64'h0000_000C;
            5:       m = 64'h0000_0014;
            6:       m = 64'h0000_0030;
            7:       m = 64'h0000_0060;
            8:       m = 64'h0000_00B8;
            12:      m = 64'h0000_0829;
            16:      m = 64'h0000_D008;
            24:      m = 64'h00E1_0000;
            32:      m = 64'h8020_0003;
            default: m = 64'd3 << (width - 2);
        endcase
        return W'(m);
    endfunction

    localparam logic [W-1:0] TAPS    = tap_mask(W);
    localparam logic [W-1:0] SEED_NZ = (SEED == '0) ? W'(1) : SEED;

    logic [W-1:0] lfsr_q, lfsr_d;
    logic         fb;

    always_comb begin
        fb     = ^(lfsr_q & TAPS);
        lfsr_d = {lfsr_q[W-2:0], fb};
        if (lfsr_d == '0) begin
            lfsr_d = SEED_NZ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED_NZ;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_low = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/otp_auth_multi.sv
// -----------------------------------------------------------------------------
// otp_auth_multi
// One-time-password authenticator. A free-running LFSR supplies the OTP when
// otp_latch pulses; the user then keys in NUM_DIGITS hex digits with
// user_latch. A full entry is compared in a one-cycle CHECK state. MAX_TRIES
// consecutive mismatches lock the block out for LOCK_CYCLES cycles. Both the
// OTP and the entry are shown on a multiplexed seven-segment display.
//
// Optional feature (macro OTP_AUTH_TIMEOUT_EN): when defined, an entry that
// sees no user_latch for TIMEOUT_CYCLES cycles is scored as a mismatch. When
// undefined, ENTRY waits forever and the timeout counter is not built.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-high
//   otp_latch   in   pulse: latch a new OTP (IDLE/ENTRY only, wins over user_latch)
//   user_latch  in   pulse: accept user_in as the next digit (ENTRY only)
//   user_in     in   entered hex digit
//   lfsr_out    out  7-seg pattern of the OTP digit under the active anode
//   user_out    out  7-seg pattern of the entered digit under the active anode
//   an          out  one-hot active-high digit select
//   otp_val     out  latched OTP, digit 0 in the LSBs
//   auth_ok     out  one-cycle pulse on match (during CHECK)
//   auth_fail   out  one-cycle pulse on mismatch (during CHECK)
//   locked      out  high during lockout
//   tries_left  out  remaining attempts
//
// state  | meaning
// IDLE   | no entry in progress; user_latch ignored
// ENTRY  | OTP held, collecting digits into entry
// CHECK  | single cycle presenting the comparison result
// LOCKED | lockout, both latches ignored until the timer expires
// -----------------------------------------------------------------------------
module otp_auth_multi
    import otp_auth_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int LFSR_W      = 16,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 1024,
    parameter int SCAN_DIV    = 16
`ifdef OTP_AUTH_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             otp_latch,
    input  logic                             user_latch,
    input  logic [3:0]                       user_in,
    output logic [6:0]                       lfsr_out,
    output logic [6:0]                       user_out,
    output logic [NUM_DIGITS-1:0]            an,
    output logic [4*NUM_DIGITS-1:0]          otp_val,
    output logic                             auth_ok,
    output logic                             auth_fail,
    output logic                             locked,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

    localparam int OTP_W  = 4 * NUM_DIGITS;
    localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int DIG_W  = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;
    localparam int SCAN_W = (SCAN_DIV > 1)    ? $clog2(SCAN_DIV)    : 1;
    localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [LFSR_W-1:0] SEED_W    = LFSR_W'(LFSR_SEED);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_DIGITS - 1);
    localparam logic [TRY_W-1:0]  TRIES_MAX = TRY_W'(MAX_TRIES);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_W-1:0] SCAN_LOAD = SCAN_W'(SCAN_DIV - 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES - 1);

`ifdef OTP_AUTH_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
`endif

    logic [OTP_W-1:0]  lfsr_low;

    state_e            state_q, state_d;
    logic [OTP_W-1:0]  otp_q, otp_d;
    logic [OTP_W-1:0]  entry_q, entry_d, entry_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TRY_W-1:0]  tries_q, tries_d;
    logic [LOCK_W-1:0] lock_q, lock_d;
    logic              ok_q, ok_d;
    logic              fail_q, fail_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [DIG_W-1:0]  dig_q, dig_d;
`ifdef OTP_AUTH_TIMEOUT_EN
    logic [TMO_W-1:0]  tmo_q, tmo_d;
`endif

    logic [3:0]        otp_dig, ent_dig;
    logic              ent_shown;

    otp_lfsr #(
        .W     (LFSR_W),
        .OUT_W (OTP_W),
        .SEED  (SEED_W)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .lfsr_low (lfsr_low)
    );

    // Controller next-state. auth_ok/auth_fail are registered on the edge
    // that enters CHECK, so the pulse coincides with the CHECK cycle and
    // CHECK itself decides on the stored result.
    always_comb begin
        state_d   = state_q;
        otp_d     = otp_q;
        entry_d   = entry_q;
        cnt_d     = cnt_q;
        tries_d   = tries_q;
        lock_d    = lock_q;
        ok_d      = 1'b0;
        fail_d    = 1'b0;
`ifdef OTP_AUTH_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif

        entry_nxt = entry_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                entry_nxt[4*i +: 4] = user_in;
            end
        end

        if (otp_latch && (state_q == ST_IDLE || state_q == ST_ENTRY)) begin
            state_d = ST_ENTRY;
            otp_d   = lfsr_low;
            entry_d = '0;
            cnt_d   = '0;
`ifdef OTP_AUTH_TIMEOUT_EN
            tmo_d   = TMO_LOAD;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                end

                ST_ENTRY: begin
                    if (user_latch) begin
                        entry_d = entry_nxt;
                        cnt_d   = cnt_q + CNT_W'(1);
`ifdef OTP_AUTH_TIMEOUT_EN
                        tmo_d   = TMO_LOAD;
`endif
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_CHECK;
                            ok_d    = (entry_nxt == otp_q);
                            fail_d  = (entry_nxt != otp_q);
                        end
                    end
`ifdef OTP_AUTH_TIMEOUT_EN
                    else if (tmo_q == '0) begin
                        state_d = ST_CHECK;
                        fail_d  = 1'b1;
                    end else begin
                        tmo_d = tmo_q - TMO_W'(1);
                    end
`endif
                end

                ST_CHECK: begin
                    entry_d = '0;
                    cnt_d   = '0;
                    if (ok_q) begin
                        tries_d = TRIES_MAX;
                        state_d = ST_IDLE;
                    end else if (tries_q <= TRY_W'(1)) begin
                        tries_d = '0;
                        lock_d  = LOCK_LOAD;
                        state_d = ST_LOCKED;
                    end else begin
                        tries_d = tries_q - TRY_W'(1);
                        state_d = ST_ENTRY;
`ifdef OTP_AUTH_TIMEOUT_EN
                        tmo_d   = TMO_LOAD;
`endif
                    end
                end

                ST_LOCKED: begin
                    if (lock_q == '0) begin
                        state_d = ST_IDLE;
                        tries_d = TRIES_MAX;
                        otp_d   = '0;
                    end else begin
                        lock_d = lock_q - LOCK_W'(1);
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Display scan: down-counter per digit, digit index wraps at the last anode.
    always_comb begin
        scan_d = scan_q - SCAN_W'(1);
        dig_d  = dig_q;
        if (scan_q == '0) begin
            scan_d = SCAN_LOAD;
            dig_d  = (dig_q == DIG_LAST) ? '0 : dig_q + DIG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            otp_q   <= '0;
            entry_q <= '0;
            cnt_q   <= '0;
            tries_q <= TRIES_MAX;
            lock_q  <= '0;
            ok_q    <= 1'b0;
            fail_q  <= 1'b0;
            scan_q  <= SCAN_LOAD;
            dig_q   <= '0;
`ifdef OTP_AUTH_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            otp_q   <= otp_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
            tries_q <= tries_d;
            lock_q  <= lock_d;
            ok_q    <= ok_d;
            fail_q  <= fail_d;
            scan_q  <= scan_d;
            dig_q   <= dig_d;
`ifdef OTP_AUTH_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Digit mux for the active anode; an entered digit is shown only once
    // its position has been filled (index below cnt).
    always_comb begin
        an        = '0;
        otp_dig   = '0;
        ent_dig   = '0;
        ent_shown = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_q == DIG_W'(i)) begin
                an[i]     = 1'b1;
                otp_dig   = otp_q[4*i +: 4];
                ent_dig   = entry_q[4*i +: 4];
                ent_shown = (cnt_q > CNT_W'(i));
            end
        end
    end

    assign lfsr_out   = (state_q == ST_ENTRY || state_q == ST_CHECK) ? hex_to_7seg(otp_dig) : 7'h00;
    assign user_out   = ent_shown ? hex_to_7seg(ent_dig) : 7'h00;
    assign otp_val    = otp_q;
    assign auth_ok    = ok_q;
    assign auth_fail  = fail_q;
    assign locked     = (state_q == ST_LOCKED);
    assign tries_left = tries_q;

endmodule

// File: tb/tb_otp_auth_multi.sv
module tb_otp_auth_multi;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       otp_latch = 1'b0;
    logic       user_latch = 1'b0;
    logic [3:0] user_in = 4'h0;
    logic [6:0] lfsr_out, user_out;
    logic [1:0] an;
    logic [7:0] otp_val;
    logic       auth_ok, auth_fail, locked;
    logic [1:0] tries_left;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected CHECK results, {ok, fail}, pushed when the final digit is driven.
    logic [1:0] sb[$];

    // Reference LFSR: x^16 + x^15 + x^13 + x^4 + 1, Fibonacci, shift toward MSB.
    logic [15:0] m_lfsr;
    int          cyc;

    logic [7:0]  otp_a, otp_b, otp_c, otp_d;
    int          n;

    otp_auth_multi #(
        .NUM_DIGITS  (2),
        .LFSR_W      (16),
        .MAX_TRIES   (3),
        .LOCK_CYCLES (1024),
        .SCAN_DIV    (16)
`ifdef OTP_AUTH_TIMEOUT_EN
       ,.TIMEOUT_CYCLES (100)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .otp_latch  (otp_latch),
        .user_latch (user_latch),
        .user_in    (user_in),
        .lfsr_out   (lfsr_out),
        .user_out   (user_out),
        .an         (an),
        .otp_val    (otp_val),
        .auth_ok    (auth_ok),
        .auth_fail  (auth_fail),
        .locked     (locked),
        .tries_left (tries_left)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            m_lfsr <= 16'hACE1;
            cyc    <= 0;
        end else begin
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3]};
            cyc    <= cyc + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg7_ref(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
            4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
            4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
            4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
        endcase
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Display check; the active digit is derived from the bench's own cycle count.
    task automatic chk_disp(input string tag, input bit show_otp, input logic [7:0] otp,
                            input int n_ent, input logic [7:0] ent);
        int d;
        d = (cyc / 16) % 2;
        chk({tag, "_an"}, {30'd0, an}, (d == 0) ? 32'd1 : 32'd2);
        chk({tag, "_lfsr_out"}, {25'd0, lfsr_out}, show_otp ? {25'd0, seg7_ref(otp[d*4 +: 4])} : 32'd0);
        chk({tag, "_user_out"}, {25'd0, user_out}, (d < n_ent) ? {25'd0, seg7_ref(ent[d*4 +: 4])} : 32'd0);
    endtask

    // Pops the scoreboard when a result pulse appears; expected immediately
    // (the CHECK cycle follows the edge that took the last digit).
    task automatic wait_result(input string tag);
        int lat;
        logic [1:0] e;
        lat = 0;
        while (!(auth_ok || auth_fail) && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 0);
        chk({tag, "_sb_size"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_auth_ok"}, {31'd0, auth_ok}, {31'd0, e[1]});
            chk({tag, "_auth_fail"}, {31'd0, auth_fail}, {31'd0, e[0]});
        end
        @(negedge clk);
        chk({tag, "_pulse_width"}, {30'd0, auth_ok, auth_fail}, 32'd0);
    endtask

    task automatic enter2(input logic [3:0] d0, input logic [3:0] d1);
        user_latch = 1'b1;
        user_in    = d0;
        @(negedge clk);
        user_in    = d1;
        @(negedge clk);
        user_latch = 1'b0;
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_otp_val", {24'd0, otp_val}, 32'd0);
        chk("rst_auth_ok", {31'd0, auth_ok}, 32'd0);
        chk("rst_auth_fail", {31'd0, auth_fail}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_tries", {30'd0, tries_left}, 32'd3);
        chk_disp("rst", 1'b0, 8'h00, 0, 8'h00);

        // ---------------- idle scan, user_latch in IDLE ----------------
        for (int i = 0; i < 64; i++) begin
            if (i > 0) @(negedge clk);
            user_latch = (i == 20);
            user_in    = 4'h5;
            chk("scan_an", {30'd0, an}, (((i / 16) % 2) == 0) ? 32'd1 : 32'd2);
            chk("scan_user_out", {25'd0, user_out}, 32'd0);
        end
        user_latch = 1'b0;
        @(negedge clk);
        chk("idle_latch_otp_val", {24'd0, otp_val}, 32'd0);
        chk("idle_latch_lfsr_out", {25'd0, lfsr_out}, 32'd0);
        chk("idle_latch_tries", {30'd0, tries_left}, 32'd3);

        // ---------------- correct entry ----------------
        otp_latch = 1'b1;
        otp_a     = m_lfsr[7:0];
        @(negedge clk);
        otp_latch = 1'b0;
        chk("match_otp_val", {24'd0, otp_val}, {24'd0, otp_a});
        chk_disp("match_e0", 1'b1, otp_a, 0, 8'h00);
        user_latch = 1'b1;
        user_in    = otp_a[3:0];
        @(negedge clk);
        user_in    = otp_a[7:4];
        chk_disp("match_e1", 1'b1, otp_a, 1, {4'h0, otp_a[3:0]});
        @(negedge clk);
        user_latch = 1'b0;
        sb.push_back(2'b10);
        wait_result("match");
        chk("match_tries", {30'd0, tries_left}, 32'd3);
        chk("match_lfsr_out_idle", {25'd0, lfsr_out}, 32'd0);

        // ---------------- three wrong entries -> lockout ----------------
        otp_latch = 1'b1;
        otp_b     = m_lfsr[7:0];
        @(negedge clk);
        otp_latch = 1'b0;
        chk("miss_otp_val", {24'd0, otp_val}, {24'd0, otp_b});
        for (int k = 0; k < 3; k++) begin
            enter2(otp_b[3:0] ^ 4'h1, otp_b[7:4]);
            sb.push_back(2'b01);
            wait_result("miss");
            chk("miss_tries", {30'd0, tries_left}, 32'(2 - k));
            chk("miss_locked", {31'd0, locked}, (k == 2) ? 32'd1 : 32'd0);
            if (k < 2) chk_disp("miss_retry", 1'b1, otp_b, 0, 8'h00);
        end

        n = 1;
        while (locked && n < 1100) begin
            otp_latch  = (n == 5);
            user_latch = (n == 5);
            user_in    = 4'h3;
            @(negedge clk);
            n++;
            if (n == 10) begin
                chk("lock_otp_hold", {24'd0, otp_val}, {24'd0, otp_b});
                chk("lock_user_out", {25'd0, user_out}, 32'd0);
                chk("lock_lfsr_out", {25'd0, lfsr_out}, 32'd0);
                chk("lock_tries", {30'd0, tries_left}, 32'd0);
            end
        end
        otp_latch  = 1'b0;
        user_latch = 1'b0;
        chk("lock_len", n - 1, 1024);
        chk("unlock_tries", {30'd0, tries_left}, 32'd3);
        chk("unlock_otp_val", {24'd0, otp_val}, 32'd0);
        chk("unlock_lfsr_out", {25'd0, lfsr_out}, 32'd0);

        // ---------------- otp_latch and user_latch together ----------------
        otp_latch = 1'b1;
        otp_c     = m_lfsr[7:0];
        @(negedge clk);
        otp_latch  = 1'b0;
        user_latch = 1'b1;
        user_in    = otp_c[3:0];
        @(negedge clk);
        chk_disp("simul_pre", 1'b1, otp_c, 1, {4'h0, otp_c[3:0]});
        otp_latch  = 1'b1;
        user_latch = 1'b1;
        user_in    = 4'hF;
        otp_d      = m_lfsr[7:0];
        @(negedge clk);
        otp_latch  = 1'b0;
        user_latch = 1'b0;
        chk("simul_otp_val", {24'd0, otp_val}, {24'd0, otp_d});
        chk_disp("simul_post", 1'b1, otp_d, 0, 8'h00);
        enter2(otp_d[3:0], otp_d[7:4]);
        sb.push_back(2'b10);
        wait_result("simul_match");
        chk("simul_tries", {30'd0, tries_left}, 32'd3);

`ifdef OTP_AUTH_TIMEOUT_EN
        // ---------------- entry timeout ----------------
        otp_latch = 1'b1;
        @(negedge clk);
        otp_latch = 1'b0;
        sb.push_back(2'b01);
        n = 1;
        while (!auth_fail && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_len", n, 101);
        wait_result("tmo");
        chk("tmo_tries", {30'd0, tries_left}, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/otp_auth_multi.md
OTP_AUTH_MULTI -- requirements
Module: otp_auth_multi

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 2: OTP/entry length in hex digits, 1..8.
REQ-002 SHALL have parameter LFSR_W, default 16: LFSR width, >= 4*NUM_DIGITS.
REQ-003 SHALL have parameter MAX_TRIES, default 3: failed attempts before lockout.
REQ-004 SHALL have parameter LOCK_CYCLES, default 1024: lockout duration in clk cycles.
REQ-005 SHALL have parameter SCAN_DIV, default 16: clk cycles per display digit.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port otp_latch, input, 1: one-cycle pulse requesting a new OTP.
REQ-009 SHALL have port user_latch, input, 1: one-cycle pulse accepting user_in as the next digit.
REQ-010 SHALL have port user_in, input, 4: entered hex digit.
REQ-011 SHALL have port lfsr_out, output, 7: seven-segment pattern (gfedcba, active-high) of the OTP digit under the active anode.
REQ-012 SHALL have port user_out, output, 7: seven-segment pattern of the entered digit under the active anode.
REQ-013 SHALL have port an, output, NUM_DIGITS: one-hot, active-high digit select.
REQ-014 SHALL have port otp_val, output, 4*NUM_DIGITS: the latched OTP, digit 0 in the LSBs.
REQ-015 SHALL have port auth_ok, output, 1: one-cycle pulse on a match.
REQ-016 SHALL have port auth_fail, output, 1: one-cycle pulse on a mismatch.
REQ-017 SHALL have port locked, output, 1: high during lockout.
REQ-018 SHALL have port tries_left, output, $clog2(MAX_TRIES+1): remaining attempts.

Function
REQ-019 SHALL step a Fibonacci LFSR every cycle; it SHALL never reach all-zero.
REQ-020 SHALL implement FSM states IDLE, ENTRY, CHECK, LOCKED.
REQ-021 IDLE/ENTRY + otp_latch: otp_val SHALL load LFSR[4*NUM_DIGITS-1:0], entry SHALL clear, next state ENTRY; otp_val valid the cycle after the pulse.
REQ-022 ENTRY + user_latch: user_in SHALL store at digit index cnt and cnt SHALL increment; when cnt reaches NUM_DIGITS the next state SHALL be CHECK.
REQ-023 IDLE + user_latch (no OTP held): SHALL be ignored.
REQ-024 CHECK SHALL last one cycle; match -> auth_ok, tries_left=MAX_TRIES, IDLE; mismatch -> auth_fail, tries_left-1, then ENTRY with entry cleared, or LOCKED if tries_left becomes 0.
REQ-025 Simultaneous otp_latch and user_latch SHALL treat otp_latch as winning and drop user_latch.
REQ-026 LOCKED SHALL ignore both latches, count LOCK_CYCLES, then go to IDLE with tries_left=MAX_TRIES and otp_val cleared.
REQ-027 an SHALL advance one position every SCAN_DIV cycles and wrap from bit NUM_DIGITS-1 to bit 0.
REQ-028 user_out SHALL be 7'h00 for digits not yet entered; lfsr_out SHALL be 7'h00 in IDLE and LOCKED.

Reset
REQ-029 On reset, the LFSR SHALL load seed 16'hACE1, truncated to LFSR_W, and the state SHALL become IDLE.
REQ-030 On reset, otp_val, entry, cnt, auth_ok, auth_fail, locked, lfsr_out and user_out SHALL be 0, an SHALL be 1, and tries_left SHALL be MAX_TRIES.
REQ-031 Reset during any state, including LOCKED, SHALL take effect on the next edge.

Configuration
REQ-032 With OTP_AUTH_TIMEOUT_EN defined, ENTRY without user_latch for TIMEOUT_CYCLES (parameter, default 4096) SHALL behave as a mismatch in CHECK.
REQ-033 Without OTP_AUTH_TIMEOUT_EN, ENTRY SHALL wait indefinitely and no timeout counter SHALL exist.

Structure
REQ-034 Package otp_auth_pkg SHALL hold the FSM state enum, the seed constant and the hex-to-7seg function.
REQ-035 The LFSR SHALL be the single sub-module otp_lfsr, parameterised by width and seed.

Verification
REQ-036 Reset, otp_latch, then enter the 2 digits of otp_val -> auth_ok pulse 1 cycle after the 2nd user_latch; tries_left=3.
REQ-037 Three wrong 2-digit entries -> auth_fail x3, tries_left 2,1,0, locked=1 for 1024 cycles, then IDLE with tries_left=3.
REQ-038 otp_latch and user_latch in the same cycle -> new otp_val loaded, entry count 0.
REQ-039 user_latch in IDLE and during LOCKED -> no change in state or outputs.
REQ-040 Idle scan over 64 cycles -> an sequence 01,10,01,10 with SCAN_DIV=16; user_out=0 before entry.
REQ-041 With OTP_AUTH_TIMEOUT_EN and TIMEOUT_CYCLES=100, 100 idle cycles in ENTRY -> auth_fail and tries_left=2.
